// File: rtl/arith_reservation_station.sv
// Reservation station for the arithmetic pipeline: holds ALU micro-ops until A/B/flag
// operands arrive on the CDB, then issues the lowest-index ready entry into registered outputs.
package arith_rs_pkg;
  typedef struct packed {
    logic       rdy;
    logic [7:0] v;    // value when rdy, else tag in [4:0]
  } opnd_t;

  typedef struct packed {
    logic [3:0] opcode;
    logic [4:0] rob;
    logic [4:0] dest;
    logic [4:0] flag_dest;
    opnd_t      a;
    opnd_t      b;
    opnd_t      f;
  } uop_t;

  function automatic opnd_t capture(opnd_t o, logic hit_v, logic [4:0] tag, logic [7:0] val);
    capture = o;
    if (!o.rdy && hit_v && o.v[4:0] == tag) begin
      capture.rdy = 1'b1;
      capture.v   = val;
    end
  endfunction
endpackage

module arith_rs_entry
  import arith_rs_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       alloc,
  input  logic       issue,
  input  uop_t       disp_uop,
  input  logic       cdb_valid,
  input  logic [4:0] cdb_reg,
  input  logic [7:0] cdb_val,
  input  logic       cdb_flag_valid,
  input  logic [4:0] cdb_flag_reg,
  input  logic [7:0] cdb_flags,
  output logic       valid,
  output logic       eligible,
  output uop_t       uop
);
  uop_t src, nxt;

  // Same capture path serves dispatch bypass and wakeup of a resident entry.
  always_comb begin
    src   = alloc ? disp_uop : uop;
    nxt   = src;
    nxt.a = capture(src.a, cdb_valid, cdb_reg, cdb_val);
    nxt.b = capture(src.b, cdb_valid, cdb_reg, cdb_val);
    nxt.f = capture(src.f, cdb_flag_valid, cdb_flag_reg, cdb_flags);
  end

  assign eligible = valid && uop.a.rdy && uop.b.rdy && uop.f.rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      uop   <= '0;
    end else begin
      uop <= nxt;
      if (flush)      valid <= 1'b0;
      else if (alloc) valid <= 1'b1;
      else if (issue) valid <= 1'b0;
    end
  end
endmodule

module arith_reservation_station
  import arith_rs_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       disp_valid,
  output logic       disp_ready,
  input  logic [3:0] disp_opcode,
  input  logic [4:0] disp_rob,
  input  logic [4:0] disp_dest,
  input  logic [4:0] disp_flag_dest,
  input  logic       disp_a_rdy,
  input  logic       disp_b_rdy,
  input  logic       disp_f_rdy,
  input  logic [7:0] disp_a,
  input  logic [7:0] disp_b,
  input  logic [7:0] disp_f,
  input  logic       cdb_valid,
  input  logic [4:0] cdb_reg,
  input  logic [7:0] cdb_val,
  input  logic       cdb_flag_valid,
  input  logic [4:0] cdb_flag_reg,
  input  logic [7:0] cdb_flags,
  output logic       instr_valid,
  output logic [3:0] opcode,
  output logic [4:0] ROB_entry,
  output logic [4:0] dest_reg,
  output logic [4:0] flag_reg,
  output logic [7:0] op_a_val,
  output logic [7:0] op_b_val,
  output logic [7:0] flags_val
);
  logic [DEPTH-1:0] ent_valid, ent_elig, alloc_oh, issue_oh;
  uop_t [DEPTH-1:0] ent_uop;
  uop_t             disp_uop, sel_uop;
  logic             any_elig;

  assign disp_uop = '{opcode: disp_opcode, rob: disp_rob, dest: disp_dest,
                      flag_dest: disp_flag_dest,
                      a: '{rdy: disp_a_rdy, v: disp_a},
                      b: '{rdy: disp_b_rdy, v: disp_b},
                      f: '{rdy: disp_f_rdy, v: disp_f}};

  assign disp_ready = ~&ent_valid;

  // Lowest free entry takes the dispatch; lowest eligible entry issues. Flush blocks both.
  always_comb begin
    logic found_free;
    alloc_oh   = '0;
    issue_oh   = '0;
    sel_uop    = '0;
    any_elig   = 1'b0;
    found_free = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!ent_valid[i] && !found_free) begin
        alloc_oh[i] = disp_valid && !flush;
        found_free  = 1'b1;
      end
      if (ent_elig[i] && !any_elig) begin
        issue_oh[i] = !flush;
        sel_uop     = ent_uop[i];
        any_elig    = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    arith_rs_entry u_ent (
      .clk, .rst_n, .flush,
      .alloc          (alloc_oh[g]),
      .issue          (issue_oh[g]),
      .disp_uop,
      .cdb_valid, .cdb_reg, .cdb_val,
      .cdb_flag_valid, .cdb_flag_reg, .cdb_flags,
      .valid          (ent_valid[g]),
      .eligible       (ent_elig[g]),
      .uop            (ent_uop[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid <= 1'b0;
      opcode      <= '0;
      ROB_entry   <= '0;
      dest_reg    <= '0;
      flag_reg    <= '0;
      op_a_val    <= '0;
      op_b_val    <= '0;
      flags_val   <= '0;
    end else if (flush || !any_elig) begin
      instr_valid <= 1'b0;
    end else begin
      instr_valid <= 1'b1;
      opcode      <= sel_uop.opcode;
      ROB_entry   <= sel_uop.rob;
      dest_reg    <= sel_uop.dest;
      flag_reg    <= sel_uop.flag_dest;
      op_a_val    <= sel_uop.a.v;
      op_b_val    <= sel_uop.b.v;
      flags_val   <= sel_uop.f.v;
    end
  end
endmodule
